// File: rtl/cube_pkg.sv
// Shared LED-cube definitions: frame geometry, sync marker, loader state
// encoding and the GRB word packing used by both loader and driver.
package cube_pkg;

    localparam int NUM_LEDS  = 64;
    localparam int ADDR_W    = 10;
    localparam int LED_IDX_W = $clog2(NUM_LEDS);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RECV_R   = 3'd1,
        ST_RECV_G   = 3'd2,
        ST_RECV_B   = 3'd3,
        ST_WRITE    = 3'd4,
        ST_RECV_CHK = 3'd5
    } loader_state_e;

    function automatic logic [23:0] pack_grb(input logic [7:0] g,
                                             input logic [7:0] r,
                                             input logic [7:0] b);
        return {g, r, b};
    endfunction

endpackage

// File: rtl/cube_frame_loader_idle_timer.sv
// Inter-byte idle counter: raises expired once TIMEOUT_CYCLES edges have
// passed while enabled without a clear.
module idle_timer #(
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear || !enable) begin
            count_d = '0;
        end else if (count_q != LIMIT) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Saturates at LIMIT so expired stays asserted until the FSM leaves.
    assign expired = enable && (count_q == LIMIT);

endmodule

// File: rtl/cube_frame_loader.sv
// Framed UART byte stream -> frame RAM writer. One GRB word per LED,
// XOR-checksummed frames, single-cycle done/error pulses.
module cube_frame_loader
    import cube_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [7:0]        RX_DATA,
    input  logic              RX_VALID,
    output logic              RX_READY,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [23:0]       WR_DATA,
    output logic              WR_EN,
    output logic              BUSY,
    output logic              FRAME_DONE,
    output logic              FRAME_ERR
);

    loader_state_e        state_q, state_d;
    logic [LED_IDX_W-1:0] led_q, led_d;
    logic [7:0]           r_q, r_d;
    logic [7:0]           g_q, g_d;
    logic [7:0]           xor_q, xor_d;
    logic                 rx_ready_q, rx_ready_d;
    logic                 wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
    logic [23:0]          wr_data_q, wr_data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic accept;
    logic tmr_enable;
    logic tmr_clear;
    logic tmr_expired;

    assign accept     = RX_VALID && rx_ready_q;
    assign tmr_enable = (state_q != ST_IDLE);
    assign tmr_clear  = accept || (state_q == ST_IDLE);

    idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk    (CLK),
        .rst    (RESET),
        .enable (tmr_enable),
        .clear  (tmr_clear),
        .expired(tmr_expired)
    );

    always_comb begin
        state_d   = state_q;
        led_d     = led_q;
        r_d       = r_q;
        g_d       = g_q;
        xor_d     = xor_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        // Byte acceptance is tested before the timeout so a byte landing on
        // the expiry edge still counts.
        case (state_q)
            ST_IDLE: begin
                if (accept && (RX_DATA == SYNC_BYTE)) begin
                    state_d = ST_RECV_R;
                    led_d   = '0;
                    xor_d   = '0;
                end
            end
            ST_RECV_R: begin
                if (accept) begin
                    r_d     = RX_DATA;
                    xor_d   = xor_q ^ RX_DATA;
                    state_d = ST_RECV_G;
                end else if (tmr_expired) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            ST_RECV_G: begin
                if (accept) begin
                    g_d     = RX_DATA;
                    xor_d   = xor_q ^ RX_DATA;
                    state_d = ST_RECV_B;
                end else if (tmr_expired) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            ST_RECV_B: begin
                if (accept) begin
                    xor_d     = xor_q ^ RX_DATA;
                    wr_addr_d = {{(ADDR_W - LED_IDX_W){1'b0}}, led_q};
                    wr_data_d = pack_grb(g_q, r_q, RX_DATA);
                    state_d   = ST_WRITE;
                end else if (tmr_expired) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            ST_WRITE: begin
                if (led_q == LED_IDX_W'(NUM_LEDS - 1)) begin
                    state_d = ST_RECV_CHK;
                end else begin
                    led_d   = led_q + LED_IDX_W'(1);
                    state_d = ST_RECV_R;
                end
            end
            ST_RECV_CHK: begin
                if (accept) begin
                    state_d = ST_IDLE;
                    if (RX_DATA == xor_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (tmr_expired) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered outputs follow the state being entered.
        rx_ready_d = (state_d != ST_WRITE);
        wr_en_d    = (state_d == ST_WRITE);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            led_q      <= '0;
            r_q        <= '0;
            g_q        <= '0;
            xor_q      <= '0;
            rx_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            led_q      <= led_d;
            r_q        <= r_d;
            g_q        <= g_d;
            xor_q      <= xor_d;
            rx_ready_q <= rx_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign RX_READY   = rx_ready_q;
    assign WR_EN      = wr_en_q;
    assign WR_ADDR    = wr_addr_q;
    assign WR_DATA    = wr_data_q;
    assign BUSY       = busy_q;
    assign FRAME_DONE = done_q;
    assign FRAME_ERR  = err_q;

endmodule
